// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared state encodings, attack pre-shift and default widths for the AGC step generator
package agc_pkg;

    typedef enum logic [1:0] {
        ST_DECAY = 2'd0,
        ST_HANG  = 2'd1
    } agc_state_e;

    localparam int ATK_PRESHIFT = 7;
    localparam int MW_DEF       = 16;
    localparam int HW_DEF       = 12;
    localparam int SW_DEF       = 24;

endpackage

// File: rtl/agc_step_gen.sv
// rtl/agc_step_gen.sv - AGC attack/hang/decay step generator feeding the gain accumulator
// Optional hold input is built in when AGC_HOLD_EN is defined.
module agc_step_gen
    import agc_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int HW = HW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [MW-1:0] mag,
    input  logic          stb,
    input  logic [MW-1:0] thr,
    input  logic [3:0]    atk,
    input  logic [3:0]    dcy,
    input  logic [HW-1:0] hang,
`ifdef AGC_HOLD_EN
    input  logic          hold,
`endif
    output logic [SW-1:0] d,
    output logic          ce,
    output logic [1:0]    st
);

    localparam int PW = MW + 1 + ATK_PRESHIFT;

    logic            w_hold;
    logic            w_take;
    logic [PW-1:0]   w_pre;
    logic [SW-1:0]   w_atk_mag;
    logic [SW-1:0]   w_atk_step;
    logic [SW-1:0]   w_dcy_step;

    logic            r_v1;
    logic [MW:0]     r_err;
    logic            r_over;
    logic [3:0]      r_atk1;
    logic [3:0]      r_dcy1;
    logic [HW-1:0]   r_hang1;

    logic [SW-1:0]   r_d;
    logic            r_ce;
    agc_state_e      r_st;
    logic [HW-1:0]   r_hcnt;

`ifdef AGC_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_take = stb & ~w_hold;

    // Control inputs travel with their sample so changes land on the next strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1    <= 1'b0;
            r_err   <= '0;
            r_over  <= 1'b0;
            r_atk1  <= '0;
            r_dcy1  <= '0;
            r_hang1 <= '0;
        end else begin
            r_v1 <= w_take;
            if (w_take) begin
                r_err   <= {1'b0, mag} - {1'b0, thr};
                r_over  <= (mag > thr);
                r_atk1  <= atk;
                r_dcy1  <= dcy;
                r_hang1 <= hang;
            end
        end
    end

    // err is only consumed when positive, so zero-extension is exact.
    assign w_pre = {r_err, {ATK_PRESHIFT{1'b0}}};

    always_comb begin
        w_atk_mag = SW'(w_pre) >> r_atk1;
    end

    assign w_atk_step = -w_atk_mag;
    assign w_dcy_step = SW'(1) << r_dcy1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d    <= '0;
            r_ce   <= 1'b0;
            r_st   <= ST_DECAY;
            r_hcnt <= '0;
        end else if (w_hold || !r_v1) begin
            r_ce <= 1'b0;
        end else if (r_over) begin
            r_d    <= w_atk_step;
            r_ce   <= 1'b1;
            r_st   <= ST_HANG;
            r_hcnt <= r_hang1;
        end else begin
            case (r_st)
                ST_HANG: begin
                    if (r_hcnt != '0) begin
                        r_hcnt <= r_hcnt - HW'(1);
                        r_ce   <= 1'b0;
                    end else begin
                        r_st <= ST_DECAY;
                        r_d  <= w_dcy_step;
                        r_ce <= 1'b1;
                    end
                end
                default: begin
                    r_st <= ST_DECAY;
                    r_d  <= w_dcy_step;
                    r_ce <= 1'b1;
                end
            endcase
        end
    end

    assign d  = r_d;
    assign ce = r_ce;
    assign st = r_st;

endmodule

// File: tb/tb_agc_step_gen.sv
// tb/tb_agc_step_gen.sv - randomized self-checking bench for agc_step_gen against a sample-level model
module tb_agc_step_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mag = '0;
    logic        stb = 1'b0;
    logic [15:0] thr = '0;
    logic [3:0]  atk = '0;
    logic [3:0]  dcy = '0;
    logic [11:0] hang = '0;
    logic [23:0] d;
    logic        ce;
    logic [1:0]  st;
`ifdef AGC_HOLD_EN
    logic        hold = 1'b0;
    wire         hold_now = hold;
`else
    wire         hold_now = 1'b0;
`endif

    agc_step_gen dut (
        .clk  (clk),
        .rst  (rst),
        .mag  (mag),
        .stb  (stb),
        .thr  (thr),
        .atk  (atk),
        .dcy  (dcy),
        .hang (hang),
`ifdef AGC_HOLD_EN
        .hold (hold),
`endif
        .d    (d),
        .ce   (ce),
        .st   (st)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit v;
        int mag;
        int thr;
        int atk;
        int dcy;
        int hang;
    } item_t;

    item_t       s1;
    bit          m_in_hang;
    int          m_left;
    logic [23:0] m_last_d;
    logic        exp_ce;
    logic [23:0] exp_d;
    logic [1:0]  exp_st;

    task automatic model_reset();
        s1.v      = 1'b0;
        m_in_hang = 1'b0;
        m_left    = 0;
        m_last_d  = '0;
    endtask

    // One sample reaching the output stage, described directly by the AGC rules.
    task automatic model_apply(input item_t it);
        longint diff;
        longint stepv;
        exp_ce = 1'b0;
        if (it.v) begin
            if (it.mag > it.thr) begin
                diff      = longint'(it.mag - it.thr);
                stepv     = (diff * 128) / (longint'(1) << it.atk);
                m_last_d  = 24'(-stepv);
                exp_ce    = 1'b1;
                m_in_hang = 1'b1;
                m_left    = it.hang;
            end else if (m_in_hang && m_left > 0) begin
                m_left = m_left - 1;
            end else begin
                m_in_hang = 1'b0;
                m_last_d  = 24'(longint'(1) << it.dcy);
                exp_ce    = 1'b1;
            end
        end
        exp_d  = m_last_d;
        exp_st = m_in_hang ? 2'd1 : 2'd0;
    endtask

    task automatic step();
        item_t nw;
        bit    h;
        h       = hold_now;
        nw.v    = stb && !h;
        nw.mag  = int'(mag);
        nw.thr  = int'(thr);
        nw.atk  = int'(atk);
        nw.dcy  = int'(dcy);
        nw.hang = int'(hang);
        @(posedge clk);
        if (h) begin
            exp_ce = 1'b0;
            exp_d  = m_last_d;
            exp_st = m_in_hang ? 2'd1 : 2'd0;
            s1.v   = 1'b0;
        end else begin
            model_apply(s1);
            s1 = nw;
        end
        #1;
    endtask

    task automatic drive(input bit s, input int m);
        stb = s;
        mag = 16'(m);
        step();
    endtask

    task automatic test_reset();
        checks++;
        if ({ce, d, st} !== {1'b0, 24'h0, 2'd0}) begin
            errors++;
            $display("FAIL reset_state: ce=%0b d=%h st=%0d expected 0/000000/0", ce, d, st);
        end
        rst = 1'b1;
        thr = 16'd1000; atk = 4'd3; dcy = 4'd2; hang = 12'd2;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, int'($urandom_range(900, 1100)));
            checks++;
            if ({ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
                errors++;
                $display("FAIL reset_prestream: ce=%0b d=%h st=%0d expected %0b/%h/%0d", ce, d, st, exp_ce, exp_d, exp_st);
            end
        end
        stb = 1'b1;
        mag = 16'd2000;
        rst = 1'b0;
        #1;
        checks++;
        if ({ce, d, st} !== {1'b0, 24'h0, 2'd0}) begin
            errors++;
            $display("FAIL reset_async: ce=%0b d=%h st=%0d expected 0/000000/0", ce, d, st);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (ce !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: ce=%0b expected 0", ce);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 0);
            checks++;
            if (ce !== 1'b0 || d !== 24'h0 || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
                errors++;
                $display("FAIL reset_release: ce=%0b d=%h expected ce=0 d=000000", ce, d);
            end
        end
    endtask

    task automatic test_attack();
        thr = 16'd1000; atk = 4'd3; dcy = 4'd2; hang = 12'd4;
        drive(1'b1, 1256);
        checks++;
        if (ce !== 1'b0) begin
            errors++;
            $display("FAIL attack_latency: ce=%0b one cycle after stb, expected 0", ce);
        end
        drive(1'b0, 0);
        checks++;
        if ({ce, d, st} !== {1'b1, 24'hFFF000, 2'd1} || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
            errors++;
            $display("FAIL attack_step: ce=%0b d=%h st=%0d expected 1/fff000/1", ce, d, st);
        end
    endtask

    task automatic test_hang_decay();
        for (int i = 0; i < 6; i++) begin
            drive(i < 5, 500);
            if (i >= 1) begin
                checks++;
                if (ce !== (i == 5) || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
                    errors++;
                    $display("FAIL hang_decay[%0d]: ce=%0b d=%h st=%0d expected %0b/%h/%0d", i, ce, d, st, exp_ce, exp_d, exp_st);
                end
            end
        end
        checks++;
        if ({d, st} !== {24'h000004, 2'd0}) begin
            errors++;
            $display("FAIL decay_value: d=%h st=%0d expected 000004/0", d, st);
        end
    endtask

    task automatic test_retrigger();
        int  mags [10];
        bit  ces  [10];
        mags = '{1256, 500, 500, 1001, 500, 500, 500, 500, 500, 0};
        ces  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        thr = 16'd1000; atk = 4'd3; dcy = 4'd2; hang = 12'd4;
        for (int i = 0; i < 10; i++) begin
            drive(i < 9, mags[i]);
            checks++;
            if (ce !== ces[i] || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
                errors++;
                $display("FAIL retrigger[%0d]: ce=%0b d=%h st=%0d expected ce=%0b model %0b/%h/%0d", i, ce, d, st, ces[i], exp_ce, exp_d, exp_st);
            end
            if (i == 4) begin
                checks++;
                if ({d, st} !== {24'hFFFFF0, 2'd1}) begin
                    errors++;
                    $display("FAIL retrigger_step: d=%h st=%0d expected fffff0/1", d, st);
                end
            end
        end
    endtask

    task automatic test_boundary();
        thr = 16'd1000; dcy = 4'd0; atk = 4'd3; hang = 12'd0;
        drive(1'b1, 1000);
        drive(1'b0, 0);
        checks++;
        if ({ce, d, st} !== {1'b1, 24'h000001, 2'd0} || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
            errors++;
            $display("FAIL equal_not_over: ce=%0b d=%h st=%0d expected 1/000001/0", ce, d, st);
        end
        thr = 16'd0; atk = 4'd0;
        drive(1'b1, 16'hFFFF);
        drive(1'b1, 0);
        checks++;
        if ({ce, d, st} !== {1'b1, 24'h800080, 2'd1} || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
            errors++;
            $display("FAIL full_scale_attack: ce=%0b d=%h st=%0d expected 1/800080/1", ce, d, st);
        end
        drive(1'b0, 0);
        checks++;
        if ({ce, d, st} !== {1'b1, 24'h000001, 2'd0} || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
            errors++;
            $display("FAIL hang_zero_decay: ce=%0b d=%h st=%0d expected 1/000001/0", ce, d, st);
        end
    endtask

    task automatic test_random();
        int m;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                thr  = 16'($urandom_range(20, 60000));
                atk  = 4'($urandom_range(0, 15));
                dcy  = 4'($urandom_range(0, 15));
                hang = 12'($urandom_range(0, 3));
            end
            m = int'(thr) + int'($urandom_range(0, 40)) - 20;
            drive(1'($urandom_range(0, 1)), m);
            checks++;
            if ({ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
                errors++;
                $display("FAIL random[%0d]: ce=%0b d=%h st=%0d expected %0b/%h/%0d", i, ce, d, st, exp_ce, exp_d, exp_st);
            end
        end
    endtask

    task automatic test_back_to_back();
        thr = 16'd30000; atk = 4'd5; dcy = 4'd4; hang = 12'd1;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, (i % 3 == 0) ? int'($urandom_range(30001, 65535)) : int'($urandom_range(0, 30000)));
            checks++;
            if ({ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: ce=%0b d=%h st=%0d expected %0b/%h/%0d", i, ce, d, st, exp_ce, exp_d, exp_st);
            end
        end
    endtask

`ifdef AGC_HOLD_EN
    task automatic test_hold();
        logic [1:0] st_frozen;
        thr = 16'd1000; atk = 4'd2; dcy = 4'd1; hang = 12'd3;
        drive(1'b1, 1500);
        hold = 1'b1;
        drive(1'b1, 1200);
        st_frozen = st;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, int'($urandom_range(0, 3000)));
            checks++;
            if (ce !== 1'b0 || st !== st_frozen || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
                errors++;
                $display("FAIL hold_freeze[%0d]: ce=%0b st=%0d expected ce=0 st=%0d", i, ce, st, st_frozen);
            end
        end
        hold = 1'b0;
        drive(1'b1, 2000);
        checks++;
        if (ce !== 1'b0) begin
            errors++;
            $display("FAIL hold_release_gap: ce=%0b expected 0", ce);
        end
        drive(1'b0, 0);
        checks++;
        if (ce !== 1'b1 || {ce, d, st} !== {exp_ce, exp_d, exp_st}) begin
            errors++;
            $display("FAIL hold_resume: ce=%0b d=%h st=%0d expected %0b/%h/%0d", ce, d, st, exp_ce, exp_d, exp_st);
        end
    endtask
`endif

    initial begin
        model_reset();
        exp_ce = 1'b0;
        exp_d  = '0;
        exp_st = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_attack();
        test_hang_decay();
        test_retrigger();
        test_boundary();
        test_random();
        test_back_to_back();
`ifdef AGC_HOLD_EN
        test_hold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
